// File: rtl/ec_sign_code_inj_gen_pkg.sv
// Shared definitions for the sign-code injection generator:
// sign code values, FSM state encodings and the code-validity helper.
package ec_sign_code_inj_gen_pkg;

   localparam logic [1:0] SIGN_POS = 2'b00;
   localparam logic [1:0] SIGN_NEG = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_INJECT = 2'b01,
      ST_DRAIN  = 2'b10,
      ST_DONE   = 2'b11
   } inj_state_e;

   // A code is legal only if it is one of the two defined sign values.
   function automatic logic sign_code_invalid(input logic [1:0] code);
      return (code != SIGN_POS) && (code != SIGN_NEG);
   endfunction

endpackage

// File: rtl/ec_sign_pred_pipe.sv
// Delay line for the predicted malfunction flag. It matches the checker's
// edge-to-flag latency and carries a valid bit that fills after reset.
module ec_sign_pred_pipe
   import ec_sign_code_inj_gen_pkg::*;
#(
   parameter int DET_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pred_in,
   output logic pred_dly,
   output logic pred_vld
);

   logic [DET_LAT-1:0] pred_sr_r;
   logic [DET_LAT-1:0] vld_sr_r;

   // Shift the prediction and a constant-one valid marker by one stage per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_sr_r <= {DET_LAT{1'b0}};
         vld_sr_r  <= {DET_LAT{1'b0}};
      end else begin
         pred_sr_r[0] <= pred_in;
         vld_sr_r[0]  <= 1'b1;
         for (int i = 1; i < DET_LAT; i++) begin
            pred_sr_r[i] <= pred_sr_r[i-1];
            vld_sr_r[i]  <= vld_sr_r[i-1];
         end
      end
   end

   assign pred_dly = pred_sr_r[DET_LAT-1];
   assign pred_vld = vld_sr_r[DET_LAT-1];

endmodule

// File: rtl/ec_sign_code_inj_gen.sv
// Transmit side of the 2-bit sign-code interface. Encodes operand signs,
// optionally overrides them with a programmed code for a number of cycles,
// predicts the checker's malfunction flag and counts disagreements.
module ec_sign_code_inj_gen
   import ec_sign_code_inj_gen_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int DET_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sign_a_in,
   input  logic             sign_b_in,
   input  logic             inj_start,
   input  logic [1:0]       inj_target,
   input  logic [1:0]       inj_code,
   input  logic [CNT_W-1:0] inj_len,
   input  logic             malf_in,
   output logic [1:0]       sign_out_A,
   output logic [1:0]       sign_out_B,
   output logic             inj_busy,
   output logic             inj_done,
   output logic             chk_err,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [2:0]       DRAIN_LOAD = 3'(DET_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   inj_state_e       state_r;
   logic [1:0]       tgt_r;
   logic [1:0]       code_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       drain_cnt_r;

   logic [1:0]       nxt_a_s;
   logic [1:0]       nxt_b_s;
   logic             pred_s;
   logic             pred_dly_s;
   logic             pred_vld_s;

   // Choose the next lane codes: latched injection code on targeted lanes while injecting.
   always_comb begin
      nxt_a_s = SIGN_POS;
      nxt_b_s = SIGN_POS;
      if ((state_r == ST_INJECT) && tgt_r[0]) begin
         nxt_a_s = code_r;
      end else if (sign_a_in) begin
         nxt_a_s = SIGN_NEG;
      end else begin
         nxt_a_s = SIGN_POS;
      end
      if ((state_r == ST_INJECT) && tgt_r[1]) begin
         nxt_b_s = code_r;
      end else if (sign_b_in) begin
         nxt_b_s = SIGN_NEG;
      end else begin
         nxt_b_s = SIGN_POS;
      end
   end

   // The checker sees the registered codes, so predict from those.
   assign pred_s = sign_code_invalid(sign_out_A) | sign_code_invalid(sign_out_B);

   ec_sign_pred_pipe #(
      .DET_LAT (DET_LAT)
   ) u_pred_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .pred_in  (pred_s),
      .pred_dly (pred_dly_s),
      .pred_vld (pred_vld_s)
   );

   // Register the lane codes driven to the checker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_out_A <= SIGN_POS;
         sign_out_B <= SIGN_POS;
      end else begin
         sign_out_A <= nxt_a_s;
         sign_out_B <= nxt_b_s;
      end
   end

   // Compare the returned flag with the aligned prediction and count mismatching cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_err   <= 1'b0;
         err_count <= {CNT_W{1'b0}};
      end else begin
         chk_err <= pred_vld_s & (malf_in ^ pred_dly_s);
         if (chk_err && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_ONE;
         end else begin
            err_count <= err_count;
         end
      end
   end

   // Injection sequencer: IDLE -> INJECT (len cycles) -> DRAIN (DET_LAT cycles) -> DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         tgt_r       <= 2'b00;
         code_r      <= 2'b00;
         cnt_r       <= {CNT_W{1'b0}};
         drain_cnt_r <= 3'd0;
         inj_busy    <= 1'b0;
         inj_done    <= 1'b0;
      end else begin
         inj_done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (inj_start) begin
                  tgt_r  <= inj_target;
                  code_r <= inj_code;
                  cnt_r  <= inj_len;
                  if (inj_len != {CNT_W{1'b0}}) begin
                     state_r  <= ST_INJECT;
                     inj_busy <= 1'b1;
                  end else begin
                     // Zero-length request completes without corrupting a cycle.
                     state_r  <= ST_DONE;
                     inj_done <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_INJECT: begin
               cnt_r <= cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_r     <= ST_DRAIN;
                  drain_cnt_r <= DRAIN_LOAD;
               end else begin
                  state_r <= ST_INJECT;
               end
            end
            ST_DRAIN: begin
               // Hold off completion until the last corrupted code has been judged.
               if (drain_cnt_r == 3'd1) begin
                  state_r  <= ST_DONE;
                  inj_busy <= 1'b0;
                  inj_done <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r - 3'd1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               inj_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
